// File: rtl/trigger_capture_pkg.sv
// Shared types and constants for the trigger capture block.
package trigger_capture_pkg;

  localparam int ADC_W = 14;
  localparam logic [7:0] HEADER_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_READOUT
  } state_e;

  // Splits an ADC code into its UART bytes: high part zero-padded, then low byte.
  function automatic logic [7:0] fmt_byte(input logic [ADC_W-1:0] s, input logic hi);
    return hi ? {2'b00, s[ADC_W-1:8]} : s[7:0];
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer with registered read, shaped for block RAM inference.
module capture_ram
  import trigger_capture_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = ADC_W
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger sample capture into a ring buffer, then framed byte readout.
// state     | meaning
// S_IDLE    | waiting for arm
// S_FILL    | collecting the pre-trigger history, trigger ignored
// S_ARMED   | ring buffer running, looking for a threshold crossing
// S_POST    | collecting post-trigger samples
// S_READOUT | streaming header plus buffer bytes to the UART
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int               DEPTH  = 64,
  parameter int               PRE    = 16,
  parameter logic [ADC_W-1:0] THRESH = 14'd9000,
  parameter logic [7:0]       HEADER = HEADER_DEF
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  input  logic             trig_slope,
  input  logic             arm,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             triggered
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TOT   = 1 + 2 * DEPTH;
  localparam int LD_W  = $clog2(TOT + 1);
  localparam logic [PTR_W-1:0] PRE_P     = PTR_W'(PRE);
  localparam logic [PTR_W-1:0] PRE_LAST  = PTR_W'(PRE - 1);
  localparam logic [PTR_W-1:0] POST_LAST = PTR_W'(DEPTH - PRE - 1);

  state_e           state_q;
  logic [PTR_W-1:0] wr_ptr_q, cnt_q, rd_ptr_q;
  logic [ADC_W-1:0] prev_q, rd_data;
  logic             prev_vld_q, triggered_q, out_valid_q;
  logic [7:0]       out_data_q, lo_q;
  logic [LD_W-1:0]  ld_cnt_q;
  logic             wr_en, hit;

  assign wr_en = sample_valid && (state_q inside {S_FILL, S_ARMED, S_POST});
  assign hit   = prev_vld_q && (trig_slope ? (prev_q >= THRESH && sample < THRESH)
                                           : (prev_q < THRESH && sample >= THRESH));

  capture_ram #(.DEPTH(DEPTH), .W(ADC_W)) u_ram (
    .clk_i   (clk_50),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (sample),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      triggered_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      lo_q        <= '0;
      ld_cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        prev_q     <= sample;
        prev_vld_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: if (arm) begin
          state_q    <= S_FILL;
          wr_ptr_q   <= '0;
          cnt_q      <= '0;
          prev_vld_q <= 1'b0;
          ld_cnt_q   <= '0;
        end
        S_FILL: if (sample_valid) begin
          if (cnt_q == PRE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_ARMED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ARMED: if (sample_valid && hit) begin
          // rd_ptr_q doubles as the latched frame start address
          rd_ptr_q    <= wr_ptr_q - PRE_P;
          triggered_q <= 1'b1;
          cnt_q       <= PTR_W'(1);
          state_q     <= (DEPTH - PRE == 1) ? S_READOUT : S_POST;
        end
        S_POST: if (sample_valid) begin
          if (cnt_q == POST_LAST) state_q <= S_READOUT;
          else cnt_q <= cnt_q + 1'b1;
        end
        S_READOUT: if (!out_valid_q || out_ready) begin
          if (ld_cnt_q == LD_W'(TOT)) begin
            out_valid_q <= 1'b0;
            triggered_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            ld_cnt_q    <= ld_cnt_q + 1'b1;
            if (ld_cnt_q == '0) begin
              out_data_q <= HEADER;
            end else if (ld_cnt_q[0]) begin
              // next sample's read overlaps the low-byte slot
              out_data_q <= fmt_byte(rd_data, 1'b1);
              lo_q       <= fmt_byte(rd_data, 1'b0);
              rd_ptr_q   <= rd_ptr_q + 1'b1;
            end else begin
              out_data_q <= lo_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign triggered = triggered_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Randomized bench for trigger_capture against a queue-based frame model.
module tb_trigger_capture;

  localparam int DEPTH  = 64;
  localparam int PRE    = 16;
  localparam int THRESH = 9000;
  localparam int TOT    = 1 + 2 * DEPTH;
  localparam int HDR    = 'hA5;

  logic        clk_50 = 1'b0;
  logic        reset, sample_valid, trig_slope, arm, out_ready;
  logic [13:0] sample;
  logic [7:0]  out_data;
  logic        out_valid, busy, triggered;

  int          n_total = 0;
  int          n_bad   = 0;
  int          stim_s[$];
  bit          stim_sl[$];
  logic [7:0]  last_got[$];

  always #10 clk_50 = ~clk_50;

  trigger_capture #(
    .DEPTH(DEPTH), .PRE(PRE), .THRESH(14'd9000), .HEADER(8'hA5)
  ) dut (
    .clk_50(clk_50), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .trig_slope(trig_slope), .arm(arm), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .triggered(triggered)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit crosses(input int p, input int x, input bit sl);
    return sl ? (p >= THRESH && x < THRESH) : (p < THRESH && x >= THRESH);
  endfunction

  function automatic logic [7:0] gb(input int k);
    return (last_got.size() > k) ? last_got[k] : 8'h00;
  endfunction

  task automatic load_pulse(input bit sl);
    stim_s.delete(); stim_sl.delete();
    for (int k = 0; k < 30; k++) stim_s.push_back(8050 + k);
    stim_s.push_back(11054); stim_s.push_back(13843); stim_s.push_back(11721);
    stim_s.push_back(9367);  stim_s.push_back(8148);
    for (int k = 0; k < 60; k++) stim_s.push_back(8060);
    foreach (stim_s[i]) stim_sl.push_back(sl);
  endtask

  task automatic load_early();
    stim_s.delete(); stim_sl.delete();
    for (int k = 0; k < 5; k++)  stim_s.push_back(8000);
    for (int k = 0; k < 5; k++)  stim_s.push_back(10000);
    for (int k = 0; k < 30; k++) stim_s.push_back(8500);
    stim_s.push_back(9500);
    for (int k = 0; k < 60; k++) stim_s.push_back(8500 + k);
    foreach (stim_s[i]) stim_sl.push_back(1'b0);
  endtask

  task automatic load_random();
    int n1;
    stim_s.delete(); stim_sl.delete();
    n1 = $urandom_range(20, 100);
    for (int k = 0; k < n1; k++) stim_s.push_back(int'($urandom_range(8700, 9300)));
    for (int k = 0; k < 10; k++) begin stim_s.push_back(8000); stim_s.push_back(10000); end
    for (int k = 0; k < 70; k++) stim_s.push_back(int'($urandom_range(0, 16383)));
    foreach (stim_s[i]) stim_sl.push_back(bit'($urandom_range(0, 1)));
  endtask

  // rmode: 0 always ready, 1 random ready, 2 ready with one 5-cycle stall at byte 60
  task automatic run_frame(input int gap, input int rmode, input int rst_byte, input bit arm_noise);
    int n, trig, last_post, si, c, post_c, first_c, last_c, stall_left;
    bit pv, done, stalled, aborted;
    logic [7:0] pd;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    n = stim_s.size();
    trig = -1;
    for (int i = PRE; i < n; i++)
      if (trig < 0 && crosses(stim_s[i-1], stim_s[i], stim_sl[i])) trig = i;
    chk("stim_has_trigger", 32'(trig >= 0 && trig + DEPTH - PRE <= n), 1);
    if (trig < 0 || trig + DEPTH - PRE > n) return;
    last_post = trig + DEPTH - PRE - 1;
    exp_q.push_back(8'(HDR));
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(8'(stim_s[trig-PRE+k] / 256));
      exp_q.push_back(8'(stim_s[trig-PRE+k] % 256));
    end

    @(negedge clk_50); arm = 1'b1; sample_valid = 1'b0;
    @(negedge clk_50); arm = 1'b0;
    chk("busy_after_arm", 32'(busy), 1);
    chk("trig_low_after_arm", 32'(triggered), 0);
    si = 0; c = 0; post_c = -100; first_c = -1; last_c = 0; stall_left = 0;
    pv = 0; done = 0; stalled = 0; aborted = 0; pd = '0;
    while (!done && !aborted && c < 4000) begin
      sample_valid = 1'b0;
      if (si < n && c % gap == 0) begin
        sample_valid = 1'b1;
        sample       = 14'(stim_s[si]);
        trig_slope   = stim_sl[si];
        if (si == last_post) post_c = c;
        si++;
      end
      arm = arm_noise && (got_q.size() < TOT - 1) && ($urandom_range(0, 4) == 0);
      if (rmode == 2 && !stalled && got_q.size() == 60) begin stalled = 1; stall_left = 5; end
      if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else if (rmode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b1;
      if (pv) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(pd));
      end
      if (out_valid && first_c < 0) begin
        first_c = c;
        chk("header_latency_ok", 32'(c > post_c && c - post_c <= 3), 1);
        chk("triggered_in_readout", 32'(triggered), 1);
      end
      if (rst_byte >= 0 && got_q.size() == rst_byte && out_valid) begin
        reset = 1'b1; sample_valid = 1'b0; arm = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_triggered", 32'(triggered), 0);
        @(negedge clk_50); reset = 1'b0; aborted = 1;
      end else begin
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
          if (rmode == 0 && got_q.size() > 1) chk("back_to_back", c, last_c + 1);
          last_c = c;
        end
        pv = out_valid && !out_ready;
        pd = out_data;
        done = (got_q.size() == TOT);
        @(negedge clk_50); c++;
      end
    end
    sample_valid = 1'b0; arm = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("byte%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
    if (!aborted) begin
      chk("byte_count", got_q.size(), TOT);
      chk("end_out_valid", 32'(out_valid), 0);
      chk("end_busy", 32'(busy), 0);
      chk("end_triggered", 32'(triggered), 0);
      @(negedge clk_50);
      chk("stay_idle", 32'(busy), 0);
    end
    last_got = got_q;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample = '0;
    trig_slope = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk_50);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_triggered", 32'(triggered), 0);
    reset = 1'b0;
    @(negedge clk_50);
    chk("idle_busy", 32'(busy), 0);

    load_pulse(1'b0); run_frame(1, 0, -1, 1'b0);
    chk("rise_b0", 32'(gb(0)), 'hA5);
    chk("rise_b1", 32'(gb(1)), 'h1F);
    chk("rise_b2", 32'(gb(2)), 'h80);
    chk("rise_b32", 32'(gb(32)), 'h8F);
    chk("rise_b33", 32'(gb(33)), 'h2B);
    chk("rise_b34", 32'(gb(34)), 'h2E);

    load_pulse(1'b1); run_frame(1, 0, -1, 1'b0);
    chk("fall_b0", 32'(gb(0)), 'hA5);
    chk("fall_b33", 32'(gb(33)), 'h1F);
    chk("fall_b34", 32'(gb(34)), 'hD4);

    load_early(); run_frame(1, 2, -1, 1'b0);
    chk("early_b33", 32'(gb(33)), 'h25);
    chk("early_b34", 32'(gb(34)), 'h1C);

    load_pulse(1'b0); run_frame(1, 0, 39, 1'b0);
    run_frame(1, 0, -1, 1'b0);
    chk("after_rst_b33", 32'(gb(33)), 'h2B);

    load_pulse(1'b0); run_frame(3, 1, -1, 1'b1);
    chk("slow_b33", 32'(gb(33)), 'h2B);
    chk("slow_b34", 32'(gb(34)), 'h2E);

    for (int r = 0; r < 6; r++) begin
      load_random();
      run_frame(int'($urandom_range(1, 3)), int'($urandom_range(0, 1)), -1,
                bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
